// File: rtl/router_pkt_pkg.sv
// Shared definitions for the router packet stream: word counts, header field
// positions, tail marker and the encap/decap FSM state type.
package router_pkt_pkg;

  localparam int FLIT_W        = 64;
  localparam int ADDR_W        = 10;
  localparam int SEQ_W         = 8;
  localparam int PKT_WORDS     = 19;
  localparam int PAYLOAD_WORDS = 16;
  localparam int PAYLOAD_W     = FLIT_W * PAYLOAD_WORDS;

  localparam int HDR_DST_LSB = 54;
  localparam int HDR_SRC_LSB = 44;
  localparam int HDR_LEN_LSB = 36;
  localparam int HDR_SEQ_LSB = 28;

  localparam logic [7:0]        PKT_LEN   = 8'(PKT_WORDS);
  localparam logic [FLIT_W-1:0] TAIL_MARK = 64'hE0F0_0000_0000_00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_CSUM,
    ST_TAIL
  } pkt_state_e;

endpackage

// File: rtl/pkt_hdr_build.sv
// Combinational formation of the header and tail flit words from the
// destination address, this node's address and the packet sequence number.
module pkt_hdr_build
  import router_pkt_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SRC_ADDR = 10'd0
) (
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [SEQ_W-1:0]  seq_i,
  output logic [FLIT_W-1:0] hdr_o,
  output logic [FLIT_W-1:0] tail_o
);

  always_comb begin
    hdr_o                               = '0;
    hdr_o[HDR_DST_LSB +: ADDR_W]        = dst_i;
    hdr_o[HDR_SRC_LSB +: ADDR_W]        = SRC_ADDR;
    hdr_o[HDR_LEN_LSB +: 8]             = PKT_LEN;
    hdr_o[HDR_SEQ_LSB +: SEQ_W]         = seq_i;
    tail_o                              = TAIL_MARK | {{(FLIT_W-SEQ_W){1'b0}}, seq_i};
  end

endmodule

// File: rtl/pkt_encap_tx.sv
// Packet encapsulator: serialises one 1024-bit payload into a 19-word flit
// stream. Define PKT_ENCAP_CHECKSUM_EN to emit an XOR checksum in word 17.
//
// Handshakes: a packet moves on a rising edge with valid_send && ready_send;
// a flit word moves on a rising edge with we_input_port && !full_input_port,
// and while full_input_port is high the presented word is held unchanged.
module pkt_encap_tx
  import router_pkt_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SRC_ADDR = 10'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PAYLOAD_W-1:0] data_arbiter_send,
  input  logic [ADDR_W-1:0]    dst_addr_arbiter_send,
  input  logic                 valid_send,
  output logic                 ready_send,
  output logic [FLIT_W-1:0]    data_in_port,
  output logic                 we_input_port,
  input  logic                 full_input_port,
  output logic                 done_encap_pkt,
  output pkt_state_e           dbg_state
);

  pkt_state_e           state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic [PAYLOAD_W-1:0] pay_q, pay_d;
  logic [FLIT_W-1:0]    data_q, data_d;
  logic                 we_q, we_d;
  logic                 ready_q, ready_d;

  logic [FLIT_W-1:0]    hdr_word, tail_word, csum_word;
  logic                 accept, word_acc;

  assign accept   = (state_q == ST_IDLE) && ready_q && valid_send;
  assign word_acc = we_q && !full_input_port;

  pkt_hdr_build #(.SRC_ADDR(SRC_ADDR)) u_hdr (
    .dst_i  (dst_addr_arbiter_send),
    .seq_i  (seq_q),
    .hdr_o  (hdr_word),
    .tail_o (tail_word)
  );

`ifdef PKT_ENCAP_CHECKSUM_EN
  logic [FLIT_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= '0;
    end else if (word_acc && (state_q == ST_HDR || state_q == ST_PAY)) begin
      csum_q <= csum_q ^ data_q;
    end
  end

  // Fold in the last payload word as it leaves, so word 17 is ready in time.
  assign csum_word = csum_q ^ data_q;
`else
  assign csum_word = '0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    pay_d   = pay_q;
    data_d  = data_q;
    we_d    = we_q;
    ready_d = ready_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          state_d = ST_HDR;
          pay_d   = data_arbiter_send;
          data_d  = hdr_word;
          we_d    = 1'b1;
          ready_d = 1'b0;
        end
      end
      ST_HDR: begin
        if (word_acc) begin
          state_d = ST_PAY;
          idx_d   = 4'd0;
          data_d  = pay_q[PAYLOAD_W-1 -: FLIT_W];
          pay_d   = pay_q << FLIT_W;
        end
      end
      ST_PAY: begin
        if (word_acc) begin
          if (idx_q == 4'(PAYLOAD_WORDS-1)) begin
            state_d = ST_CSUM;
            data_d  = csum_word;
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = pay_q[PAYLOAD_W-1 -: FLIT_W];
            pay_d  = pay_q << FLIT_W;
          end
        end
      end
      ST_CSUM: begin
        if (word_acc) begin
          state_d = ST_TAIL;
          data_d  = tail_word;
        end
      end
      ST_TAIL: begin
        // ready stays low for the first IDLE cycle after the tail.
        if (word_acc) begin
          state_d = ST_IDLE;
          data_d  = '0;
          we_d    = 1'b0;
          seq_d   = seq_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
        data_d  = '0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
      pay_q   <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      pay_q   <= pay_d;
      data_q  <= data_d;
      we_q    <= we_d;
      ready_q <= ready_d;
    end
  end

  assign ready_send     = ready_q;
  assign data_in_port   = data_q;
  assign we_input_port  = we_q;
  assign done_encap_pkt = (state_q == ST_TAIL) && word_acc;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_pkt_encap_tx.sv
// Directed and randomised bench for pkt_encap_tx against a word-list model of
// the flit stream.
module tb_pkt_encap_tx;
  import router_pkt_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1023:0]  data_arbiter_send = '0;
  logic [9:0]     dst_addr_arbiter_send = '0;
  logic           valid_send = 1'b0;
  logic           ready_send;
  logic [63:0]    data_in_port;
  logic           we_input_port;
  logic           full_input_port = 1'b0;
  logic           done_encap_pkt;
  pkt_state_e     dbg_state;

  pkt_encap_tx dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .data_arbiter_send     (data_arbiter_send),
    .dst_addr_arbiter_send (dst_addr_arbiter_send),
    .valid_send            (valid_send),
    .ready_send            (ready_send),
    .data_in_port          (data_in_port),
    .we_input_port         (we_input_port),
    .full_input_port       (full_input_port),
    .done_encap_pkt        (done_encap_pkt),
    .dbg_state             (dbg_state)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_words[19];
  logic [7:0]  seq_m = 8'd0;
  longint      cyc = 0;
  longint      acc_times[$];

  always @(posedge clk) begin
    cyc++;
    if (valid_send && ready_send && rst_n) acc_times.push_back(cyc);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference stream: header, payload MSB word first, checksum, tail.
  task automatic build_exp(input logic [9:0] dst, input logic [1023:0] pay, input logic [7:0] seq);
    logic [63:0] w, cs;
    exp_q.delete();
    w = {dst, 10'd0, 8'd19, seq, 28'd0};
    exp_q.push_back(w);
    cs = w;
    for (int i = 0; i < 16; i++) begin
      w = pay[1023 - 64*i -: 64];
      exp_q.push_back(w);
      cs = cs ^ w;
    end
`ifdef PKT_ENCAP_CHECKSUM_EN
    exp_q.push_back(cs);
`else
    exp_q.push_back(64'd0);
`endif
    exp_q.push_back(64'h00E0_F000_0000_0000 | {56'd0, seq});
  endtask

  task automatic run_pkt(input logic [9:0] dst, input logic [1023:0] pay,
                         input int stall_at, input int stall_len, input bit tail_stall,
                         input bit keep_valid, input int rst_at, output int we_cyc);
    int w, stall_cnt, guard;
    bit tstalled;
    build_exp(dst, pay, seq_m);
    we_cyc = 0;
    guard = 0;
    while (ready_send !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", {63'd0, ready_send}, 64'd1);
    data_arbiter_send     = pay;
    dst_addr_arbiter_send = dst;
    valid_send            = 1'b1;
    @(negedge clk);
    if (!keep_valid) valid_send = 1'b0;
    data_arbiter_send     = ~pay;
    dst_addr_arbiter_send = ~dst;
    w = 0; stall_cnt = 0; tstalled = 0; guard = 0;
    while (w < 19 && guard < 100) begin
      guard++;
      if (rst_at == w) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_data", data_in_port, 64'd0);
        check("rst_we", {63'd0, we_input_port}, 64'd0);
        check("rst_ready", {63'd0, ready_send}, 64'd1);
        check("rst_done", {63'd0, done_encap_pkt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        full_input_port = 1'b0;
        seq_m = 8'd0;
        return;
      end
      full_input_port = 1'b0;
      if (w == stall_at && stall_cnt < stall_len) begin
        full_input_port = 1'b1;
        stall_cnt++;
      end else if (w == 18 && tail_stall && !tstalled) begin
        full_input_port = 1'b1;
        tstalled = 1'b1;
      end
      #1;
      check("we", {63'd0, we_input_port}, 64'd1);
      check("ready_busy", {63'd0, ready_send}, 64'd0);
      check($sformatf("word%0d", w), data_in_port, exp_q[w]);
      check($sformatf("done%0d", w), {63'd0, done_encap_pkt},
            {63'd0, (w == 18 && !full_input_port)});
      if (we_input_port) we_cyc++;
      if (!full_input_port) begin
        last_words[w] = data_in_port;
        w++;
      end
      @(negedge clk);
    end
    full_input_port = 1'b0;
    check("word_count", 64'(w), 64'd19);
    check("we_after", {63'd0, we_input_port}, 64'd0);
    check("ready_gap", {63'd0, ready_send}, 64'd0);
    check("done_after", {63'd0, done_encap_pkt}, 64'd0);
    seq_m = seq_m + 8'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    seq_m = 8'd0;
  endtask

  function automatic logic [1023:0] rand_pay();
    logic [1023:0] p;
    for (int i = 0; i < 32; i++) p[32*i +: 32] = $urandom;
    return p;
  endfunction

  initial begin
    logic [1023:0] pay;
    logic [63:0]   hdr;
    int            wc;

    repeat (3) @(negedge clk);
    check("reset_ready", {63'd0, ready_send}, 64'd1);
    check("reset_we", {63'd0, we_input_port}, 64'd0);
    check("reset_data", data_in_port, 64'd0);
    check("reset_done", {63'd0, done_encap_pkt}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});

    // full while idle must not start anything
    full_input_port = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_full_we", {63'd0, we_input_port}, 64'd0);
    check("idle_full_ready", {63'd0, ready_send}, 64'd1);
    full_input_port = 1'b0;

    // single packet, incrementing bytes
    for (int b = 0; b < 128; b++) pay[1023 - 8*b -: 8] = 8'(b);
    run_pkt(10'h155, pay, -1, 0, 1'b0, 1'b0, -1, wc);
    check("p1_we_cycles", 64'(wc), 64'd19);
    check("p1_word1", last_words[1], 64'h0001020304050607);
    hdr = last_words[0];
    check("p1_hdr_dst", 64'(hdr[63:54]), 64'h155);
    check("p1_hdr_len", 64'(hdr[43:36]), 64'd19);
    check("p1_hdr_seq", 64'(hdr[35:28]), 64'd0);

    // backpressure: 3 cycles at payload word 5, 1 cycle at tail
    run_pkt(10'($urandom), rand_pay(), 6, 3, 1'b1, 1'b0, -1, wc);
    check("bp_we_cycles", 64'(wc), 64'd23);

    // back-to-back with valid held high
    do_reset();
    acc_times.delete();
    for (int k = 0; k < 3; k++) begin
      run_pkt(10'($urandom), rand_pay(), -1, 0, 1'b0, (k < 2), -1, wc);
      check($sformatf("b2b_hdr_seq%0d", k), 64'(last_words[0][35:28]), 64'(k));
      check($sformatf("b2b_tail_seq%0d", k), 64'(last_words[18][7:0]), 64'(k));
    end
    check("b2b_accepts", 64'(acc_times.size()), 64'd3);
    if (acc_times.size() == 3) begin
      check("b2b_gap0", 64'(acc_times[1] - acc_times[0]), 64'd21);
      check("b2b_gap1", 64'(acc_times[2] - acc_times[1]), 64'd21);
    end

    // checksum with all-ones payload
    run_pkt(10'($urandom), {1024{1'b1}}, -1, 0, 1'b0, 1'b0, -1, wc);
`ifdef PKT_ENCAP_CHECKSUM_EN
    check("csum_eq_hdr", last_words[17], last_words[0]);
`else
    check("csum_zero", last_words[17], 64'd0);
`endif

    // async reset at payload word 8, then a fresh packet
    run_pkt(10'($urandom), rand_pay(), -1, 0, 1'b0, 1'b0, 9, wc);
    run_pkt(10'($urandom), rand_pay(), -1, 0, 1'b0, 1'b0, -1, wc);
    check("post_rst_seq", 64'(last_words[0][35:28]), 64'd0);

    // sequence wrap: packet 257 carries seq 0
    do_reset();
    for (int k = 0; k < 257; k++) begin
      run_pkt(10'($urandom), rand_pay(), -1, 0, ($urandom_range(0, 3) == 0), 1'b0, -1, wc);
    end
    check("wrap_hdr_seq", 64'(last_words[0][35:28]), 64'd0);
    check("wrap_tail_seq", 64'(last_words[18][7:0]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_encap_tx.md
# pkt_encap_tx

Packet encapsulator and transmitter for the input side of a router port. Accepts one 1024-bit payload plus a 10-bit destination address from the local arbiter. Emits it as a 19-word, 64-bit flit stream: header, 16 payload words, checksum, tail. This is the stream format the output-port decapsulator consumes. Sits between the local arbiter and the port input queue, with word-level backpressure from the queue.

## Interface
- SRC_ADDR, 10'd0: this node's address, placed in header
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- data_arbiter_send  input  1024  payload to transmit
- dst_addr_arbiter_send  input  10  destination address
- valid_send  input  1  arbiter presents a packet
- ready_send  output  1  block can accept a packet
- data_in_port  output  64  flit word toward input queue
- we_input_port  output  1  flit word valid
- full_input_port  input  1  queue cannot accept a word this cycle
- done_encap_pkt  output  1  one-cycle pulse with the tail word's acceptance

## Operation
- Packet accepted on a rising edge with valid_send=1 and ready_send=1. Payload and address are registered and held internally; inputs may change afterwards.
- Word order (index 0..18):
  - 0, header: [63:54] dst_addr, [53:44] SRC_ADDR, [43:36] 8'd19, [35:28] seq, [27:0] zero.
  - 1..16, payload: word i = data[1023-64*(i-1) -: 64], MSB word first.
  - 17, checksum (see Configuration).
  - 18, tail: 64'hE0F0_0000_0000_00, seq in [7:0].
- seq: 8-bit counter, increments after each tail acceptance, wraps 255→0.
- FSM states:
  - IDLE: ready_send=1. Goes to HDR on accept.
  - HDR: goes to PAY on word accept.
  - PAY: 4-bit index counts 0..15. Goes to CSUM after word 15 is accepted.
  - CSUM: goes to TAIL on accept.
  - TAIL: goes to IDLE on accept.
- Word transfer: a word is accepted on a rising edge where we_input_port=1 and full_input_port=0.
- Backpressure: while full_input_port=1, we_input_port stays 1, data_in_port holds, and the FSM and index do not advance.
- ready_send=0 in every state except IDLE. valid_send outside IDLE is ignored.

## Timing
- Reset values: ready_send=1, we_input_port=0, data_in_port=0, done_encap_pkt=0, seq=0, state IDLE.
- Outputs are registered. Header appears the cycle after the accept edge.
- Unstalled packet: we_input_port high for exactly 19 consecutive cycles.
- done_encap_pkt is high during the tail-word cycle. If the tail is stalled, it is high only in the cycle the tail is accepted.
- ready_send returns to 1 the cycle after tail acceptance. Minimum spacing is 21 cycles from accept to accept: 19 word cycles, 1 IDLE accept cycle, 1 cycle of registered header.
- full_input_port asserted while idle has no effect.
- rst_n asserted mid-packet: immediately returns to the reset state and drops the packet. Nothing partial is resumed after release.

## Configuration
- PKT_ENCAP_CHECKSUM_EN defined: word 17 = XOR of header and the 16 payload words. Computed incrementally as each word is accepted, in a 64-bit accumulator cleared on packet accept.
- PKT_ENCAP_CHECKSUM_EN undefined: word 17 = 64'h0, and no accumulator is synthesized.
- Word count and timing are identical in both builds.

## Structure
- Shared package router_pkt_pkg holds:
  - typedef of FSM state enum
  - PKT_WORDS=19, PAYLOAD_WORDS=16, FLIT_W=64, ADDR_W=10, TAIL_MARK constant
  - header field bit positions
- Same package is used by the output-port decapsulator.
- One natural sub-module: pkt_hdr_build, a combinational header/tail word formation from dst, SRC_ADDR and seq. Everything else is in the top.

## Test plan
- Reset, then one packet: dst=10'h155, payload bytes incrementing 0x00..0x7F, no backpressure.
  - Expect 19 consecutive words; header [63:54]=0x155, [43:36]=19, seq=0.
  - Word 1 = 64'h0001020304050607.
  - done_encap_pkt on word 18.
- Backpressure: full_input_port high for 3 cycles at payload word 5 and 1 cycle at tail.
  - No word dropped or duplicated; data held while stalled.
  - done_encap_pkt only on the tail accept cycle.
  - 23 we cycles total.
- Back-to-back: valid_send held high for 3 packets.
  - Accepts spaced 21 cycles.
  - seq 0,1,2 in header and tail.
  - ready_send=0 throughout each transfer.
- Checksum (macro defined): payload all 64'hFFFF_FFFF_FFFF_FFFF.
  - Word 17 = header (16 payload words XOR to zero).
  - Undefined build: word 17 = 0.
- Async reset at payload word 8.
  - Outputs zero immediately, ready_send=1.
  - Next packet starts with header seq=0.
- seq wrap: send 257 packets.
  - Packet 257 carries seq=0.
